// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop FSM, tick prescaler and preload select for a 16-bit BCD stopwatch
//   c_clk    in   clock
//   R        in   synchronous active-high reset
//   P        in   raw start/stop button (asynchronous)
//   sel      in   mode: 0 up from 0000, 1 up from load, 2 down from 9999, 3 down from load
//   load     in   BCD preload for the two upper digits (nibbles above 9 clamp to 9)
//   count    in   current BCD value from the counter datapath
//   C_clr    out  datapath clear/preload level, high in IDLE
//   C_cnt    out  one-cycle count enable per tick
//   init_val out  preload value: live in IDLE, latched otherwise
//   cstate   out  0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
//   done     out  high in DONE
// Define DEBOUNCE_EN to require DEB_CYCLES stable cycles on P before a level is accepted.
module stopwatch_ctrl #(
    parameter int TICK_DIV   = 1000000,
    parameter int DEB_CYCLES = 500000
) (
    input  logic        c_clk,
    input  logic        R,
    input  logic        P,
    input  logic [1:0]  sel,
    input  logic [7:0]  load,
    input  logic [15:0] count,
    output logic        C_clr,
    output logic        C_cnt,
    output logic [15:0] init_val,
    output logic [1:0]  cstate,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam int            PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    if (TICK_DIV < 2 || DEB_CYCLES < 1) begin : g_bad_param
        $error("stopwatch_ctrl: TICK_DIV must be >= 2 and DEB_CYCLES >= 1");
    end

    state_t        state_q;
    logic          s1_q, s2_q, prev_q, lvl, press, tick, term;
    logic [PW-1:0] pre_q;
    logic [1:0]    mode_q;
    logic [15:0]   init_q, live;
    logic          clr_q, cnt_q, done_q;

    function automatic logic [3:0] clamp(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

`ifdef DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);
    logic [DW-1:0] deb_cnt_q;
    logic          deb_q;
    // Any return of the synchronised level to the accepted one restarts the count.
    always_ff @(posedge c_clk) begin
        if (R) begin
            deb_q     <= 1'b0;
            deb_cnt_q <= '0;
        end else if (s2_q == deb_q) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DW'(DEB_CYCLES - 1)) begin
            deb_q     <= s2_q;
            deb_cnt_q <= '0;
        end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
        end
    end
    assign lvl = deb_q;
`else
    assign lvl = s2_q;
`endif

    assign press    = lvl & ~prev_q;
    assign tick     = pre_q == PMAX;
    assign term     = mode_q[1] ? (count == 16'h0000) : (count == 16'h9999);
    assign live     = (sel == 2'd0) ? 16'h0000 :
                      (sel == 2'd2) ? 16'h9999 : {clamp(load[7:4]), clamp(load[3:0]), 8'h00};
    assign init_val = (state_q == IDLE) ? live : init_q;
    assign C_clr    = clr_q;
    assign C_cnt    = cnt_q;
    assign done     = done_q;
    assign cstate   = state_q;

    // Prescaler only advances in RUN; a press coinciding with a tick swallows that tick.
    always_ff @(posedge c_clk) begin
        if (R) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            prev_q  <= 1'b0;
            state_q <= IDLE;
            pre_q   <= '0;
            mode_q  <= 2'd0;
            init_q  <= 16'h0000;
            clr_q   <= 1'b1;
            cnt_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            s1_q   <= P;
            s2_q   <= s1_q;
            prev_q <= lvl;
            cnt_q  <= 1'b0;
            case (state_q)
                IDLE: if (press) begin
                    state_q <= RUN;
                    clr_q   <= 1'b0;
                    mode_q  <= sel;
                    init_q  <= live;
                end
                RUN: begin
                    pre_q <= tick ? '0 : pre_q + 1'b1;
                    if (press) state_q <= PAUSE;
                    else if (tick && term) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else cnt_q <= tick;
                end
                PAUSE: if (press) state_q <= RUN;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM that sequences the stopwatch BCD counter datapath. It turns the raw start/stop button into a single press event, prescales c_clk into count ticks, and selects the mode-dependent preload value. It drives the datapath clear and count enables and detects terminal count: 99.99 for up modes, 00.00 for down modes. It sits between the button/switch inputs and the 16-bit BCD counter.

Parameters:
TICK_DIV, 1000000, c_clk cycles per count tick (100 MHz / 1e6 = 100 Hz, 0.01 s resolution); minimum 2
DEB_CYCLES, 500000, stable cycles required on P before a level is accepted (used only with DEBOUNCE_EN)

Ports:
c_clk  in  1  system clock; the only clock
R  in  1  reset, synchronous, active-high
P  in  1  raw start/stop button, asynchronous to c_clk
sel  in  2  mode: 0 up from 0000, 1 up from load, 2 down from 9999, 3 down from load
load  in  8  BCD preload for the two upper digits
count  in  16  current BCD value fed back from the counter datapath
C_clr  out  1  datapath clear/preload strobe (level)
C_cnt  out  1  one-cycle count-enable pulse per tick
init_val  out  16  BCD preload value for the datapath
cstate  out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
done  out  1  high while in DONE

Behaviour:
- Reset: R sampled on the rising edge of c_clk.
  - cstate=IDLE, prescaler=0, synchroniser and edge flops=0, latched mode=0.
  - Outputs after reset: C_clr=1, C_cnt=0, done=0, init_val=16'h0000.
- R has priority over every other event in every state.
- Press detect:
  - P passes through a 2-flop synchroniser, then a registered edge detect.
  - press = sync_out & ~prev, which is one cycle wide.
  - P held high generates exactly one press.
  - The state changes on the 3rd c_clk edge after P is first sampled high.
- init_val is driven from live sel/load while in IDLE:
  - mode 0 = 0000
  - mode 1 = {load,8'h00}
  - mode 2 = 9999
  - mode 3 = {load,8'h00}
  - Any load nibble >9 is clamped to 9.
- Mode latch: sel and init_val are latched on the IDLE->RUN transition. Changes to sel/load outside IDLE are ignored.
- Transitions:
  - IDLE: C_clr=1; press -> RUN.
  - RUN: C_clr=0; prescaler counts 0..TICK_DIV-1, and tick is asserted when it equals TICK_DIV-1, after which it wraps to 0.
    - On tick with count not terminal: C_cnt=1 for that cycle.
    - On tick with count terminal: no C_cnt pulse; go to DONE.
    - press -> PAUSE.
    - press and tick in the same cycle: press wins, no C_cnt pulse.
  - PAUSE: prescaler holds its value, C_cnt=0; press -> RUN, and the prescaler resumes from the held value.
  - DONE: C_cnt=0, done=1, press ignored; only R leaves DONE (to IDLE).
- Terminal count:
  - latched mode 0/1: count==16'h9999
  - latched mode 2/3: count==16'h0000
  - Starting in a terminal state (e.g. mode 3 with load=00) reaches DONE on the first tick.
- Prescaler is reset to 0 on entry to IDLE.
- Outputs C_clr, C_cnt and done are registered; cstate is the state register.
- R mid-operation: the next cycle is IDLE with C_clr=1 and any pending tick is discarded.

Optional Feature:
DEBOUNCE_EN
- Defined:
  - The synchronised P must hold a new level for DEB_CYCLES consecutive cycles before it propagates to the edge detector.
  - Any glitch shorter than that restarts the stability counter.
  - Press latency becomes DEB_CYCLES+3 edges.
  - The counter is reset by R.
- Undefined: no debounce logic and no counter; latency is 3 edges; DEB_CYCLES is unused.

Test Plan:
- Reset, TICK_DIV=4: assert R 2 cycles -> cstate=0, C_clr=1, C_cnt=0, done=0, init_val=0000; sel=1, load=8'h42 in IDLE -> init_val=16'h4200.
- Start counting: sel=0, pulse P high 5 cycles -> cstate=1 on the 3rd edge, exactly one press; C_cnt pulses every 4 cycles; holding P produces no further transitions.
- Pause/resume: press in RUN -> PAUSE, no C_cnt for 20 cycles; press again -> RUN, and the first C_cnt arrives after the remaining held prescaler cycles.
- Up terminal: sel=0, model count=16'h9999 while RUN -> at the next tick no C_cnt, cstate=3, done=1; further presses ignored; R -> IDLE.
- Down/clamp: sel=3, load=8'hA3 -> init_val=16'h9300; drive count=16'h0000 in RUN -> DONE at the next tick; changing sel in RUN does not change init_val or the terminal rule.
- Simultaneous/reset: press coincident with tick -> PAUSE, no C_cnt; R asserted together with press in PAUSE -> IDLE.
  - With DEBOUNCE_EN and DEB_CYCLES=8: a 5-cycle P glitch gives no transition; a 12-cycle pulse gives one transition.
